preamble_burst_gate: RTL and testbench
======================================

// Module: preamble_burst_gate
// PURPOSE
//  Downstream of preamble_detect. Qualifies each peak_stb against the autocorrelation and power magnitudes.
//  On a qualified peak, gates a burst of burst_len full-rate IQ samples onto an AXI-stream output, terminated by tlast.
//  Enforces a holdoff after each burst. Feeds the packet demod/capture path.
// PARAMETERS
//  DATA_WIDTH   16    I/Q sample width and magnitude width
//  MAX_BURST    4095  largest burst length accepted; sets the counter width to $clog2(MAX_BURST+1)
//  HOLDOFF      1024  input handshakes dropped after a burst before re-arming (0 = none)
//  THR_SHIFT    3     qualify when acorr_mag >= pow_mag - (pow_mag >> THR_SHIFT)
// PORTS
//  clk              in   1             clock
//  reset            in   1             synchronous, active-high
//  clear            in   1             synchronous, active-high; same effect as reset
//  in_tvalid        in   1             input sample valid
//  in_tready        out  1             input sample ready
//  in_itdata        in   DATA_WIDTH    input I sample
//  in_qtdata        in   DATA_WIDTH    input Q sample
//  peak_stb         in   1             detector peak strobe (single cycle)
//  acorr_mag_tdata  in   DATA_WIDTH    |autocorr|, valid with peak_stb
//  pow_mag_tdata    in   DATA_WIDTH    |power|, valid with peak_stb
//  burst_len        in   CW            burst length, latched at trigger
//  out_tdata        out  2*DATA_WIDTH  {I,Q}
//  out_tvalid       out  1             output valid
//  out_tready       in   1             output ready
//  out_tlast        out  1             marks the last sample of the burst
//  busy             out  1             state != IDLE
//  trig_cnt         out  16            accepted triggers, saturating
//  miss_cnt         out  16            triggers ignored while busy, saturating
// BEHAVIOUR
//  Reset/clear:
//   - state=IDLE, counters=0, trig_cnt=miss_cnt=0, busy=0.
//   - Outputs follow the IDLE rules below: out_tvalid=0, out_tlast=0, in_tready=1.
//  Qualification:
//   - qual = peak_stb && (acorr_mag >= pow_mag - (pow_mag>>THR_SHIFT)).
//   - Unsigned compare, computed at DATA_WIDTH+1 bits; pow_mag=0 qualifies any peak.
//  IDLE:
//   - in_tready=1; samples are consumed and dropped; out_tvalid=0.
//   - qual -> BURST at the next cycle. Latch len = (burst_len==0 ? 1 : min(burst_len, MAX_BURST)).
//   - On trigger: cnt=0, trig_cnt++.
//   - A sample handshaked in the same cycle as qual is dropped.
//  BURST:
//   - Combinational pass-through, zero latency:
//     out_tvalid=in_tvalid, in_tready=out_tready, out_tdata={in_itdata,in_qtdata}.
//   - cnt increments per output handshake.
//   - out_tlast = (cnt==len-1), held stable while stalled.
//   - A handshake with tlast -> HOLDOFF (hcnt=0), or IDLE if HOLDOFF==0.
//  HOLDOFF:
//   - in_tready=1, samples dropped, out_tvalid=0.
//   - hcnt increments per input handshake; on hcnt==HOLDOFF-1 handshake -> IDLE.
//  Triggers outside IDLE:
//   - qual in BURST/HOLDOFF is ignored; miss_cnt++ (saturates at 16'hFFFF).
//   - qual in the cycle HOLDOFF exits also counts as a miss; re-arm takes effect the next cycle.
//  Other rules:
//   - burst_len changes outside the trigger cycle have no effect on an active burst.
//   - reset/clear mid-BURST aborts at once: the packet is truncated without tlast. This is permitted and documented for the consumer.
//   - trig_cnt, miss_cnt and all state are registered; the only combinational paths are BURST data/valid/ready.
// TESTING
//  1 reset high 4 cycles, random in -> out_tvalid=0, in_tready=1, busy=0, counters=0.
//  2 pow=1000, acorr=900, peak_stb, burst_len=8, out_tready=1 ->
//    exactly 8 samples out, tlast on sample 8 only, trig_cnt=1.
//  3 pow=1000, acorr=800 with peak_stb -> rejected: no output, trig_cnt=0, miss_cnt=0.
//  4 burst_len=16, out_tready toggled 50% random ->
//    16 samples in order, no loss or duplication, tlast stable while stalled.
//  5 HOLDOFF=4: second qual at burst sample 5 and at holdoff sample 2 -> miss_cnt=2.
//    A qual 1 cycle after holdoff exit -> a new burst, trig_cnt=2.
//  6 burst_len=0 -> 1-sample burst with tlast; burst_len=MAX_BURST+5 -> MAX_BURST samples.
//    clear at sample 3 -> IDLE next cycle, no tlast emitted.

Source files
------------

// File: rtl/preamble_burst_gate.sv
// Qualifies detector peaks against autocorrelation/power and gates a fixed-length
// IQ burst onto an AXI-stream output, followed by an input-counted holdoff.
module preamble_burst_gate #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 4095,
  parameter int unsigned HOLDOFF    = 1024,
  parameter int unsigned THR_SHIFT  = 3,
  localparam int unsigned CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic [DATA_WIDTH-1:0]   in_itdata,
  input  logic [DATA_WIDTH-1:0]   in_qtdata,
  input  logic                    peak_stb,
  input  logic [DATA_WIDTH-1:0]   acorr_mag_tdata,
  input  logic [DATA_WIDTH-1:0]   pow_mag_tdata,
  input  logic [CW-1:0]           burst_len,
  output logic [2*DATA_WIDTH-1:0] out_tdata,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_tlast,
  output logic                    busy,
  output logic [15:0]             trig_cnt,
  output logic [15:0]             miss_cnt
);

  localparam int unsigned HW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned HLAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam logic [CW-1:0] MAXL = CW'(MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_HOLD} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d, len, len_d;
  logic [HW-1:0]   hcnt, hcnt_d;
  logic [15:0]     trig_cnt_d, miss_cnt_d;
  logic [DATA_WIDTH:0] thr;
  logic            qual;

  // Threshold computed one bit wider so the subtraction can never wrap.
  assign thr  = {1'b0, pow_mag_tdata} - {1'b0, pow_mag_tdata >> THR_SHIFT};
  assign qual = peak_stb && ({1'b0, acorr_mag_tdata} >= thr);

  assign out_tdata = {in_itdata, in_qtdata};
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state    <= S_IDLE;
      cnt      <= '0;
      len      <= '0;
      hcnt     <= '0;
      trig_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      len      <= len_d;
      hcnt     <= hcnt_d;
      trig_cnt <= trig_cnt_d;
      miss_cnt <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    len_d      = len;
    hcnt_d     = hcnt;
    trig_cnt_d = trig_cnt;
    miss_cnt_d = miss_cnt;
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    in_tready  = 1'b1;

    // Any peak seen while not armed is counted as a miss.
    if (state != S_IDLE && qual && miss_cnt != 16'hFFFF)
      miss_cnt_d = miss_cnt + 16'd1;

    case (state)
      S_IDLE: begin
        if (qual) begin
          state_d = S_BURST;
          cnt_d   = '0;
          if (burst_len == '0)
            len_d = CW'(1);
          else if (burst_len > MAXL)
            len_d = MAXL;
          else
            len_d = burst_len;
          if (trig_cnt != 16'hFFFF)
            trig_cnt_d = trig_cnt + 16'd1;
        end
      end
      S_BURST: begin
        out_tvalid = in_tvalid;
        in_tready  = out_tready;
        out_tlast  = (cnt == len - CW'(1));
        if (in_tvalid && out_tready) begin
          cnt_d = cnt + CW'(1);
          if (out_tlast) begin
            cnt_d  = '0;
            hcnt_d = '0;
            state_d = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (in_tvalid) begin
          hcnt_d = hcnt + HW'(1);
          if (hcnt == HW'(HLAST))
            state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_preamble_burst_gate.sv
// Directed/randomized bench for preamble_burst_gate against a countdown-style
// behavioural model (samples remaining / holdoff handshakes remaining).
module tb_preamble_burst_gate;

  localparam int DW = 16;
  localparam int MB = 20;
  localparam int HO = 4;
  localparam int CW = $clog2(MB + 1);

  logic            clk = 1'b0;
  logic            reset, clear;
  logic            in_tvalid, in_tready;
  logic [DW-1:0]   in_itdata, in_qtdata;
  logic            peak_stb;
  logic [DW-1:0]   acorr_mag_tdata, pow_mag_tdata;
  logic [CW-1:0]   burst_len;
  logic [2*DW-1:0] out_tdata;
  logic            out_tvalid, out_tready, out_tlast, busy;
  logic [15:0]     trig_cnt, miss_cnt;

  always #5 clk = ~clk;

  preamble_burst_gate #(
    .DATA_WIDTH(DW), .MAX_BURST(MB), .HOLDOFF(HO), .THR_SHIFT(3)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .in_itdata(in_itdata), .in_qtdata(in_qtdata),
    .peak_stb(peak_stb), .acorr_mag_tdata(acorr_mag_tdata), .pow_mag_tdata(pow_mag_tdata),
    .burst_len(burst_len),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tlast(out_tlast), .busy(busy), .trig_cnt(trig_cnt), .miss_cnt(miss_cnt)
  );

  int total = 0;
  int bad   = 0;
  // Model: samples still owed in the current burst, holdoff handshakes still owed.
  int m_left = 0, m_hold = 0, m_trig = 0, m_miss = 0;
  int hs_cnt = 0, last_cnt = 0;
  bit tv_rand = 1'b1, rdy_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit pk);
    bit m_burst, qual;
    int thr, blen;
    @(negedge clk);
    peak_stb   = pk;
    in_itdata  = DW'($urandom);
    in_qtdata  = DW'($urandom);
    in_tvalid  = tv_rand  ? 1'($urandom_range(0, 1)) : 1'b1;
    out_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    m_burst = (m_left > 0);
    chk("busy",       32'(busy),       32'(m_burst || m_hold > 0));
    chk("in_tready",  32'(in_tready),  32'(m_burst ? out_tready : 1'b1));
    chk("out_tvalid", 32'(out_tvalid), 32'(m_burst ? in_tvalid : 1'b0));
    chk("out_tlast",  32'(out_tlast),  32'(m_burst && m_left == 1));
    if (m_burst) chk("out_tdata", out_tdata, {in_itdata, in_qtdata});
    chk("trig_cnt", 32'(trig_cnt), m_trig);
    chk("miss_cnt", 32'(miss_cnt), m_miss);
    if (out_tvalid && out_tready) begin
      hs_cnt++;
      if (out_tlast) last_cnt++;
    end
    thr  = int'(pow_mag_tdata) - int'(pow_mag_tdata) / 8;
    qual = pk && (int'(acorr_mag_tdata) >= thr);
    blen = int'(burst_len);
    if (reset || clear) begin
      m_left = 0; m_hold = 0; m_trig = 0; m_miss = 0;
    end else if (m_burst) begin
      if (qual) m_miss++;
      if (in_tvalid && out_tready) begin
        m_left--;
        if (m_left == 0) m_hold = HO;
      end
    end else if (m_hold > 0) begin
      if (qual) m_miss++;
      if (in_tvalid) m_hold--;
    end else if (qual) begin
      m_trig++;
      m_left = (blen == 0) ? 1 : ((blen > MB) ? MB : blen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; peak_stb = 1'b0;
    in_tvalid = 1'b0; in_itdata = '0; in_qtdata = '0; out_tready = 1'b1;
    acorr_mag_tdata = '0; pow_mag_tdata = '0; burst_len = '0;
    @(posedge clk);
    #1;

    // 1: reset held with qualifying peaks and random input
    pow_mag_tdata = 16'd1000; acorr_mag_tdata = 16'd2000;
    repeat (4) cyc(1'b1);
    reset = 1'b0;
    chk("t1_busy", 32'(busy), 32'd0);

    // 2: qualified peak, 8-sample burst
    acorr_mag_tdata = 16'd900; burst_len = CW'(8);
    hs_cnt = 0; last_cnt = 0;
    cyc(1'b1);
    repeat (60) cyc(1'b0);
    chk("t2_samples", hs_cnt, 8);
    chk("t2_tlast", last_cnt, 1);
    chk("t2_trig", 32'(trig_cnt), 1);

    // 3: acorr below threshold -> rejected
    do_reset();
    acorr_mag_tdata = 16'd800;
    hs_cnt = 0;
    cyc(1'b1);
    repeat (10) cyc(1'b0);
    chk("t3_samples", hs_cnt, 0);
    chk("t3_trig", 32'(trig_cnt), 0);
    chk("t3_miss", 32'(miss_cnt), 0);

    // 4: 16-sample burst under random backpressure
    acorr_mag_tdata = 16'd900; burst_len = CW'(16); rdy_rand = 1'b1;
    hs_cnt = 0; last_cnt = 0;
    cyc(1'b1);
    repeat (150) cyc(1'b0);
    chk("t4_samples", hs_cnt, 16);
    chk("t4_tlast", last_cnt, 1);
    chk("t4_trig", 32'(trig_cnt), 1);

    // 5: misses during burst and holdoff, re-arm right after holdoff exit
    do_reset();
    tv_rand = 1'b0; rdy_rand = 1'b0; burst_len = CW'(8);
    cyc(1'b1);
    repeat (4) cyc(1'b0);
    cyc(1'b1);
    repeat (3) cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    repeat (2) cyc(1'b0);
    chk("t5_miss", 32'(miss_cnt), 2);
    cyc(1'b1);
    chk("t5_trig", 32'(trig_cnt), 2);
    repeat (8) cyc(1'b0);
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    chk("t5_exit_miss", 32'(miss_cnt), 3);
    chk("t5_exit_trig", 32'(trig_cnt), 3);
    repeat (20) cyc(1'b0);

    // 6: zero length, over-length clamp, clear mid-burst
    do_reset();
    tv_rand = 1'b1; burst_len = '0;
    hs_cnt = 0; last_cnt = 0;
    cyc(1'b1);
    repeat (20) cyc(1'b0);
    chk("t6_len0_samples", hs_cnt, 1);
    chk("t6_len0_tlast", last_cnt, 1);
    burst_len = CW'(MB + 5);
    hs_cnt = 0; last_cnt = 0;
    cyc(1'b1);
    repeat (120) cyc(1'b0);
    chk("t6_clamp_samples", hs_cnt, MB);
    chk("t6_clamp_tlast", last_cnt, 1);
    tv_rand = 1'b0; burst_len = CW'(10);
    hs_cnt = 0; last_cnt = 0;
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    clear = 1'b1;
    cyc(1'b0);
    clear = 1'b0;
    chk("t6_clear_samples", hs_cnt, 3);
    chk("t6_clear_tlast", last_cnt, 0);
    chk("t6_clear_idle", 32'(busy), 0);
    cyc(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
